cpu_irq_controller: RTL

//  External-interrupt controller feeding the core's mei_pending input. Collects MEI_PORTS

---
 rtl/cpu_irq_controller_pkg.sv | 26 ++
 rtl/cpu_irq_controller_gateway.sv | 59 +++++
 rtl/cpu_irq_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cpu_irq_controller_pkg.sv
// Shared register offsets, widths and gateway state encoding for the
// external-interrupt controller.
package cpu_irq_controller_pkg;

    localparam int ID_W   = 5;
    localparam int PRIO_W = 3;

    localparam logic [7:0] ADDR_PENDING   = 8'h00;
    localparam logic [7:0] ADDR_ENABLE    = 8'h04;
    localparam logic [7:0] ADDR_CLAIM     = 8'h08;
    localparam logic [7:0] ADDR_COMPLETE  = 8'h0C;
    localparam logic [7:0] ADDR_THRESHOLD = 8'h10;
    localparam logic [7:0] ADDR_PRIO_BASE = 8'h20;

    typedef enum logic [1:0] {
        GW_IDLE       = 2'd0,
        GW_PENDING    = 2'd1,
        GW_IN_SERVICE = 2'd2
    } gw_state_e;

    // Byte offset of the PRIORITY register for zero-based source index idx.
    function automatic logic [7:0] prio_addr(input int idx);
        return ADDR_PRIO_BASE + 8'(4 * idx);
    endfunction

endpackage

// File: rtl/cpu_irq_controller_gateway.sv
// Per-source gateway: input synchronizer followed by an IDLE/PENDING/IN_SERVICE FSM.
module cpu_irq_gateway
    import cpu_irq_controller_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_raw,
    input  logic claim,
    input  logic complete,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_r;
    gw_state_e              state_r;
    gw_state_e              state_next_s;

    // Synchronizer shift chain for the asynchronous source line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], irq_raw};
        end
    end

    // Gateway state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= GW_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: PENDING is sticky until claimed; the line is ignored while in service.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            GW_IDLE: begin
                if (sync_r[SYNC_STAGES-1]) state_next_s = GW_PENDING;
                else                       state_next_s = GW_IDLE;
            end
            GW_PENDING: begin
                if (claim) state_next_s = GW_IN_SERVICE;
                else       state_next_s = GW_PENDING;
            end
            GW_IN_SERVICE: begin
                if (complete) state_next_s = GW_IDLE;
                else          state_next_s = GW_IN_SERVICE;
            end
            default: state_next_s = GW_IDLE;
        endcase
    end

    assign pending = (state_r == GW_PENDING);

endmodule

// File: rtl/cpu_irq_controller.sv
// External-interrupt controller: gateways, register window and best-ID arbiter.
// Optional per-source priority/threshold enabled by defining CPU_IRQ_PRIORITY_EN.
module cpu_irq_controller
    import cpu_irq_controller_pkg::*;
#(
    parameter int MEI_PORTS   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MEI_PORTS-1:0] irq_src,
    input  logic                 bus_sel,
    input  logic [7:0]           bus_addr,
    input  logic [31:0]          bus_wdata,
    input  logic [3:0]           bus_wenable,
    output logic [31:0]          bus_rdata,
    output logic                 mei_pending
);

    logic [MEI_PORTS-1:0] gw_pending_s;
    logic [MEI_PORTS-1:0] enable_r;
    logic [MEI_PORTS-1:0] eligible_s;
    logic [MEI_PORTS-1:0] claim_s;
    logic [MEI_PORTS-1:0] complete_s;
    logic [PRIO_W-1:0]    prio_s [MEI_PORTS];
    logic [PRIO_W-1:0]    thresh_s;
    logic [PRIO_W-1:0]    best_prio_s;
    logic [ID_W-1:0]      best_id_s;
    logic [7:0]           offset_s;
    logic                 wr_s;
    logic                 claim_wr_s;
    logic                 complete_wr_s;
    logic                 mei_pending_r;
    logic [31:0]          rdata_s;
    logic                 unused_s;

    assign offset_s      = {bus_addr[7:2], 2'b00};
    assign wr_s          = bus_sel && (|bus_wenable);
    assign claim_wr_s    = bus_sel && bus_wenable[0] && (offset_s == ADDR_CLAIM);
    assign complete_wr_s = wr_s && (offset_s == ADDR_COMPLETE);
    assign unused_s      = ^{bus_addr[1:0], bus_wdata};

    for (genvar g = 0; g < MEI_PORTS; g++) begin : g_src
        assign claim_s[g]    = claim_wr_s && (best_id_s == ID_W'(g + 1));
        assign complete_s[g] = complete_wr_s && (bus_wdata[ID_W-1:0] == ID_W'(g + 1));

        cpu_irq_gateway #(.SYNC_STAGES(SYNC_STAGES)) u_gw (
            .clk      (clk),
            .rst_n    (rst_n),
            .irq_raw  (irq_src[g]),
            .claim    (claim_s[g]),
            .complete (complete_s[g]),
            .pending  (gw_pending_s[g])
        );
    end

    // ENABLE register; each bit follows the write-enable of its byte lane.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable_r <= {MEI_PORTS{1'b0}};
        end else if (wr_s && (offset_s == ADDR_ENABLE)) begin
            for (int i = 0; i < MEI_PORTS; i++) begin
                if (bus_wenable[2'(i / 8)]) enable_r[i] <= bus_wdata[i];
            end
        end
    end

`ifdef CPU_IRQ_PRIORITY_EN
    logic [PRIO_W-1:0] prio_r [MEI_PORTS];
    logic [PRIO_W-1:0] thresh_r;

    // THRESHOLD and PRIORITY registers, all in byte lane 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            thresh_r <= 3'd0;
            for (int i = 0; i < MEI_PORTS; i++) prio_r[i] <= 3'd0;
        end else if (wr_s && bus_wenable[0]) begin
            if (offset_s == ADDR_THRESHOLD) thresh_r <= bus_wdata[PRIO_W-1:0];
            for (int i = 0; i < MEI_PORTS; i++) begin
                if (offset_s == prio_addr(i)) prio_r[i] <= bus_wdata[PRIO_W-1:0];
            end
        end
    end

    // Programmed priorities feed the arbiter.
    always_comb begin
        thresh_s = thresh_r;
        for (int i = 0; i < MEI_PORTS; i++) prio_s[i] = prio_r[i];
    end
`else
    // Fixed equal priority above a zero threshold: lowest ID always wins.
    always_comb begin
        thresh_s = 3'd0;
        for (int i = 0; i < MEI_PORTS; i++) prio_s[i] = 3'd1;
    end
`endif

    // Arbiter: strict greater-than keeps the lowest ID on priority ties.
    always_comb begin
        best_id_s   = 5'd0;
        best_prio_s = 3'd0;
        for (int i = 0; i < MEI_PORTS; i++) begin
            eligible_s[i] = gw_pending_s[i] && enable_r[i] && (prio_s[i] > thresh_s);
            if (eligible_s[i] && (prio_s[i] > best_prio_s)) begin
                best_id_s   = ID_W'(i + 1);
                best_prio_s = prio_s[i];
            end else begin
                best_id_s   = best_id_s;
                best_prio_s = best_prio_s;
            end
        end
    end

    // Core request, one cycle behind the arbiter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mei_pending_r <= 1'b0;
        end else begin
            mei_pending_r <= (best_id_s != 5'd0);
        end
    end

    // Read mux; COMPLETE and unmapped offsets read zero.
    always_comb begin
        rdata_s = 32'd0;
        case (offset_s)
            ADDR_PENDING: rdata_s[MEI_PORTS-1:0] = gw_pending_s;
            ADDR_ENABLE:  rdata_s[MEI_PORTS-1:0] = enable_r;
            ADDR_CLAIM:   rdata_s[ID_W-1:0]      = best_id_s;
            default: begin
`ifdef CPU_IRQ_PRIORITY_EN
                rdata_s[PRIO_W-1:0] = (offset_s == ADDR_THRESHOLD) ? thresh_r : 3'd0;
                for (int i = 0; i < MEI_PORTS; i++) begin
                    rdata_s[PRIO_W-1:0] = rdata_s[PRIO_W-1:0] |
                        ((offset_s == prio_addr(i)) ? prio_r[i] : 3'd0);
                end
`else
                rdata_s = 32'd0;
`endif
            end
        endcase
    end

    assign bus_rdata   = rdata_s;
    assign mei_pending = mei_pending_r;

endmodule
